// File: rtl/reg_file_scoreboard.sv
// Register file with two combinational read ports, one write port, same-cycle
// write bypass, optional hardwired zero register and a per-register pending bit.
module reg_file_scoreboard #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   a_select,
    input  logic [ADDR_W-1:0]   b_select,
    output logic [WIDTH-1:0]    port_a,
    output logic [WIDTH-1:0]    port_b,
    output logic                a_ready,
    output logic                b_ready,
    input  logic [WIDTH-1:0]    port_c,
    input  logic [ADDR_W-1:0]   c_select,
    input  logic                load_enable,
    input  logic                reserve_enable,
    input  logic [ADDR_W-1:0]   reserve_select,
    output logic [DEPTH-1:0]    pending
);

    localparam bit HAS_ZERO = (ZERO_REG != 0);

    logic [WIDTH-1:0]  r_regs [DEPTH];
    logic [DEPTH-1:0]  r_pending;

    logic              w_write_ok;
    logic              w_reserve_ok;
    logic [DEPTH-1:0]  w_pending_next;

    assign w_write_ok   = load_enable    && !(HAS_ZERO && (c_select == '0));
    assign w_reserve_ok = reserve_enable && !(HAS_ZERO && (reserve_select == '0));

    // A reservation is applied after the write clear so a newer producer wins.
    always_comb begin
        w_pending_next = r_pending;
        if (w_write_ok) begin
            w_pending_next[c_select] = 1'b0;
        end
        if (w_reserve_ok) begin
            w_pending_next[reserve_select] = 1'b1;
        end
        if (HAS_ZERO) begin
            w_pending_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_pending <= '0;
        end else begin
            if (w_write_ok) begin
                r_regs[c_select] <= port_c;
            end
            r_pending <= w_pending_next;
        end
    end

    assign pending = r_pending;

    logic w_bypass_a;
    logic w_bypass_b;

    assign w_bypass_a = rst_n && load_enable && (c_select == a_select);
    assign w_bypass_b = rst_n && load_enable && (c_select == b_select);

    // Zero register outranks bypass, which outranks stored state.
    always_comb begin
        port_a  = r_regs[a_select];
        a_ready = ~r_pending[a_select];
        if (HAS_ZERO && (a_select == '0)) begin
            port_a  = '0;
            a_ready = 1'b1;
        end else if (w_bypass_a) begin
            port_a  = port_c;
            a_ready = 1'b1;
        end
    end

    always_comb begin
        port_b  = r_regs[b_select];
        b_ready = ~r_pending[b_select];
        if (HAS_ZERO && (b_select == '0)) begin
            port_b  = '0;
            b_ready = 1'b1;
        end else if (w_bypass_b) begin
            port_b  = port_c;
            b_ready = 1'b1;
        end
    end

endmodule

// File: doc/reg_file_scoreboard.md
# reg_file_scoreboard

Parametrised register file with two combinational read ports, one synchronous write port, same-cycle write-to-read bypass, optional hardwired zero register and a per-register pending (scoreboard) bit. It replaces the fixed 16×32 register file in the datapath. Issue logic reserves a destination register when an instruction is dispatched. The write-back path clears the reservation when the result lands. Read ports report whether their operand is usable this cycle.

## Interface
- WIDTH, 32, data width of every register and port
- DEPTH, 16, number of registers; must equal 2**ADDR_W
- ADDR_W, 4, register address width
- ZERO_REG, 0, when 1 register 0 reads as zero, ignores writes and reservations, never pending

- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  reset, synchronous, active-low
- a_select  input  ADDR_W  read address, port A
- b_select  input  ADDR_W  read address, port B
- port_a  output  WIDTH  read data, port A (combinational)
- port_b  output  WIDTH  read data, port B (combinational)
- a_ready  output  1  port A data is valid this cycle
- b_ready  output  1  port B data is valid this cycle
- port_c  input  WIDTH  write data
- c_select  input  ADDR_W  write address
- load_enable  input  1  write strobe
- reserve_enable  input  1  mark reserve_select pending
- reserve_select  input  ADDR_W  register to reserve
- pending  output  DEPTH  scoreboard bit vector; bit i = register i awaiting write

## Operation
- Storage: DEPTH×WIDTH flops plus DEPTH pending flops; no memory macro.
- Write: on rising clk with rst_n=1 and load_enable=1, reg[c_select] <= port_c and pending[c_select] <= 0. The pending bit is not cleared if the same register is reserved in the same cycle.
- Reserve: on rising clk with rst_n=1 and reserve_enable=1, pending[reserve_select] <= 1. Reserving an already-pending register is legal; the bit stays 1 and no error is raised.
- Simultaneous write and reserve to the same register: data is written, pending ends at 1. The reservation wins and represents a newer producer.
- Write and reserve to different registers in the same cycle are independent.
- Read X ∈ {A, B}, evaluated combinationally in priority order:
  - ZERO_REG=1 and x_select=0: port_x=0, x_ready=1.
  - Bypass hit (rst_n=1, load_enable=1, c_select==x_select, and not the zero register): port_x=port_c, x_ready=1.
  - Otherwise: port_x=reg[x_select], x_ready=~pending[x_select].
- Bypass does not look at reserve_enable. A same-cycle reserve does not make the current read not-ready; it affects reads from the next cycle.
- Both ports may address the same register; they return identical results.
- With ZERO_REG=1, writes and reserves to address 0 are ignored: storage is unchanged and pending[0] is held at 0.
- Out-of-range addresses cannot occur because DEPTH=2**ADDR_W.

## Timing
- Reset: on any rising clk with rst_n=0, all registers <= 0 and all pending <= 0. load_enable and reserve_enable are ignored that cycle.
- While rst_n=0, bypass is suppressed and reads show stored contents.
- After the first reset edge: port_a=port_b=0, a_ready=b_ready=1, pending=0.
- Reset asserted with reservations outstanding discards them. A write arriving after reset release is an ordinary write.
- Read latency: 0 cycles, combinational from x_select, stored state and write-port inputs.
- Write-to-read latency:
  - Visible same cycle through bypass.
  - Visible from storage on the cycle after the edge.
- Reserve-to-pending latency: 1 edge. pending and x_ready reflect the reservation from the next cycle.
- No handshake back-pressure. Issue logic must stall on x_ready=0; the block never blocks a write or reserve.

## Test plan
- Reset: preload reg[3]=0xDEADBEEF and pending[3]=1, hold rst_n=0 one edge with load_enable=1 → reg[3]=0, pending=0x0000, a_ready=1 with a_select=3.
- Write/read: write 0x12345678 to r5. Next cycle a_select=b_select=5 → both ports 0x12345678, both ready.
- Bypass: r7=0x1. In one cycle, load_enable=1, c_select=7, port_c=0xA5A5A5A5, a_select=7 → port_a=0xA5A5A5A5 that cycle. r7 holds it next cycle.
- Scoreboard:
  - Reserve r9 → next cycle pending[9]=1, b_select=9 gives b_ready=0.
  - Write r9=0x55 → same cycle b_ready=1, port_b=0x55; next cycle pending[9]=0.
- Simultaneous reserve and write r2 (data 0x77) → next cycle reg[2]=0x77, pending[2]=1, a_ready=0 with a_select=2.
- ZERO_REG=1: write 0xFFFFFFFF and reserve at r0 → port_a=0 and a_ready=1 both in the same cycle and the next; pending[0]=0. With ZERO_REG=0 the same stimulus stores 0xFFFFFFFF.
